// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic sequencer.
// Defining TRAFFIC_PED_EN adds the pedestrian WALK state.
package traffic_pkg;

    localparam int unsigned LampW = 3;

    localparam logic [LampW-1:0] RED    = 3'b100;
    localparam logic [LampW-1:0] GREEN  = 3'b010;
    localparam logic [LampW-1:0] YELLOW = 3'b001;

`ifdef TRAFFIC_PED_EN
    typedef enum logic [1:0] {StAllRed, StGreen, StYellow, StWalk} state_e;
`else
    typedef enum logic [1:0] {StAllRed, StGreen, StYellow} state_e;
`endif

    // Lamp pattern for one direction; only the granted direction leaves RED.
    function automatic logic [LampW-1:0] lamp_for(state_e st, logic granted);
        logic [LampW-1:0] lamp;
        lamp = RED;
        if (granted && st == StGreen) begin
            lamp = GREEN;
        end else if (granted && st == StYellow) begin
            lamp = YELLOW;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: samples a duration on load and flags the last enabled cycle of the phase.
// A duration of 0 behaves as 1.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] duration_i,
    output logic             done_o
);

    logic [CNT_W-1:0] dur_q, dur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        dur_d = dur_q;
        cnt_d = cnt_q;
        if (load_i) begin
            dur_d = duration_i;
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dur_q <= duration_i;
            cnt_q <= '0;
        end else begin
            dur_q <= dur_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = enable_i && ((dur_q <= CNT_W'(1)) || (cnt_q >= dur_q - CNT_W'(1)));

endmodule

// File: rtl/traffic_sequencer.sv
// Round-robin traffic light sequencer: ALL_RED -> GREEN(dir) -> YELLOW(dir) -> ALL_RED(dir+1).
// Defining TRAFFIC_PED_EN adds a WALK phase requested through ped_req.
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_DIR = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [CNT_W-1:0]           green_time,
    input  logic [CNT_W-1:0]           yellow_time,
    input  logic [CNT_W-1:0]           allred_time,
    input  logic                       ped_req,
    output logic [LampW*NUM_DIR-1:0]   light,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic                       walk
);

    localparam int unsigned     DirW    = $clog2(NUM_DIR);
    localparam logic [DirW-1:0] LastDir = DirW'(NUM_DIR - 1);

    state_e                   state_q, state_d;
    logic [DirW-1:0]          dir_q, dir_d;
    logic [LampW*NUM_DIR-1:0] light_q, light_d;
    logic                     timer_done;
    logic                     timer_load;
    logic [CNT_W-1:0]         phase_dur;

`ifdef TRAFFIC_PED_EN
    logic walk_q, walk_d;
    logic ped_q, ped_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (timer_done) begin
            case (state_q)
                StAllRed: begin
`ifdef TRAFFIC_PED_EN
                    state_d = ped_q ? StWalk : StGreen;
`else
                    state_d = StGreen;
`endif
                end
                StGreen:  state_d = StYellow;
                StYellow: begin
                    state_d = StAllRed;
                    dir_d   = (dir_q == LastDir) ? '0 : dir_q + DirW'(1);
                end
`ifdef TRAFFIC_PED_EN
                StWalk:   state_d = StAllRed;
`endif
                default:  state_d = StAllRed;
            endcase
        end
    end

    // The duration of the phase being entered is captured on the entry edge.
    always_comb begin
        phase_dur = allred_time;
        if (!reset) begin
            case (state_d)
                StGreen:  phase_dur = green_time;
                StYellow: phase_dur = yellow_time;
`ifdef TRAFFIC_PED_EN
                StWalk:   phase_dur = green_time;
`endif
                default:  phase_dur = allred_time;
            endcase
        end
    end

    assign timer_load = reset || timer_done;

    phase_timer #(
        .CNT_W(CNT_W)
    ) u_phase_timer (
        .clock     (clock),
        .reset     (reset),
        .load_i    (timer_load),
        .enable_i  (enable),
        .duration_i(phase_dur),
        .done_o    (timer_done)
    );

    always_comb begin
        light_d = '0;
        for (int unsigned d = 0; d < NUM_DIR; d++) begin
            light_d[d*LampW +: LampW] = lamp_for(state_d, dir_d == DirW'(d));
        end
    end

`ifdef TRAFFIC_PED_EN
    always_comb begin
        walk_d = (state_d == StWalk);
        ped_d  = ped_q;
        if (state_d == StWalk && state_q != StWalk) begin
            ped_d = 1'b0;
        end else if (ped_req && state_q != StWalk) begin
            ped_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StAllRed;
            dir_q   <= '0;
            light_q <= {NUM_DIR{RED}};
`ifdef TRAFFIC_PED_EN
            walk_q  <= 1'b0;
            ped_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            light_q <= light_d;
`ifdef TRAFFIC_PED_EN
            walk_q  <= walk_d;
            ped_q   <= ped_d;
`endif
        end
    end

    assign light      = light_q;
    assign active_dir = dir_q;
`ifdef TRAFFIC_PED_EN
    assign walk       = walk_q;
`else
    assign walk       = 1'b0;
`endif

endmodule
